// File: rtl/reg_file_mp.sv
// Parametrised register file: one write port, NUM_READ registered read ports with write bypass.
// Optional busy-bit scoreboard for hazard detection, enabled by defining REGFILE_SCOREBOARD_EN.
module reg_file_mp #(
    parameter int  NUM_REGS = 32,
    parameter int  DATA_W   = 32,
    parameter int  NUM_READ = 2,
    parameter int  ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_READ-1:0]          rd_en,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         issue_en,
    input  logic [ADDR_W-1:0]            issue_addr
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_legal;

    // Register 0 is never written when hardwired, so its reset value of 0 persists.
    assign wr_legal = wr_en && !(ZERO_EN && (wr_addr == '0));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_legal) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_rd;
    logic [NUM_REGS-1:0] wr_clr;
    logic [NUM_REGS-1:0] iss_set;

    always_comb begin
        wr_clr  = '0;
        iss_set = '0;
        if (wr_legal) begin
            wr_clr[wr_addr] = 1'b1;
        end
        if (issue_en && !(ZERO_EN && (issue_addr == '0))) begin
            iss_set[issue_addr] = 1'b1;
        end
    end

    // Readers see the write clear but not the same-edge issue; issue wins in storage.
    assign busy_rd = busy_q & ~wr_clr;
    assign busy_d  = busy_rd | iss_set;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    logic unused_issue;
    assign unused_issue = ^{issue_en, issue_addr};
`endif

    for (genvar g = 0; g < NUM_READ; g++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic              hit_wr;
        logic [DATA_W-1:0] data_d;
        logic [DATA_W-1:0] data_q;

        assign addr    = rd_addr[g*ADDR_W +: ADDR_W];
        assign is_zero = ZERO_EN && (addr == '0);
        assign hit_wr  = wr_legal && (wr_addr == addr);

        always_comb begin
            data_d = regs_q[addr];
            if (is_zero) begin
                data_d = '0;
            end else if (hit_wr) begin
                data_d = wr_data;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
            end else if (rd_en[g]) begin
                data_q <= data_d;
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = data_q;

`ifdef REGFILE_SCOREBOARD_EN
        logic busy_d_p;
        logic busy_q_p;

        assign busy_d_p = is_zero ? 1'b0 : busy_rd[addr];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                busy_q_p <= 1'b0;
            end else if (rd_en[g]) begin
                busy_q_p <= busy_d_p;
            end
        end

        assign rd_busy[g] = busy_q_p;
`else
        assign rd_busy[g] = 1'b0;
`endif
    end

endmodule
